// File: rtl/stack_up_arbiter_pkg.sv
// Shared framing encodings, arbiter state type and default widths
// for the stack-up arbiter.
package stack_up_arbiter_pkg;

   localparam logic [1:0] CNTL_MOM     = 2'b00;
   localparam logic [1:0] CNTL_SOM     = 2'b01;
   localparam logic [1:0] CNTL_EOM     = 2'b10;
   localparam logic [1:0] CNTL_SOM_EOM = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } arb_state_e;

   localparam int DEF_NUM_CHAN   = 4;
   localparam int DEF_DATA_W     = 64;
   localparam int DEF_OOB_W      = 32;
   localparam int DEF_TYPE_W     = 2;
   localparam int DEF_FIFO_DEPTH = 4;

   // EOM and SOM_EOM both close a packet
   function automatic logic is_eom(input logic [1:0] c);
      return c[1];
   endfunction

endpackage

// File: rtl/stack_up_arb_fifo.sv
// Per-channel word FIFO, power-of-two depth, head word exposed
// combinationally so a word can leave the cycle after it lands.
module stack_up_arb_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         push_i,
   input  logic [W-1:0] wdata_i,
   input  logic         pop_i,
   output logic [W-1:0] rdata_o,
   output logic         empty_o,
   output logic         full_o
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_q;
   logic [PW-1:0] rd_q;
   logic [PW:0]   cnt_q;
   logic [PW:0]   cnt_d;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (cnt_q == (PW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_q];

   always_comb begin
      cnt_d = cnt_q;
      unique case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= wdata_i;
   end

endmodule

// File: rtl/stack_up_arbiter.sv
// Packet-locked round-robin merge of NUM_CHAN framed streams.
// STACK_UP_ARB_PROTO_CHK_EN adds per-channel framing error flags.
module stack_up_arbiter
   import stack_up_arbiter_pkg::*;
#(
   parameter int NUM_CHAN   = DEF_NUM_CHAN,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int OOB_W      = DEF_OOB_W,
   parameter int TYPE_W     = DEF_TYPE_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   localparam int CW        = $clog2(NUM_CHAN)
) (
   input  logic                       clk,
   input  logic                       reset_poweron,
   input  logic [NUM_CHAN-1:0]        mgr__stu__valid,
   input  logic [2*NUM_CHAN-1:0]      mgr__stu__cntl,
   output logic [NUM_CHAN-1:0]        stu__mgr__ready,
   input  logic [TYPE_W*NUM_CHAN-1:0] mgr__stu__type,
   input  logic [DATA_W*NUM_CHAN-1:0] mgr__stu__data,
   input  logic [OOB_W*NUM_CHAN-1:0]  mgr__stu__oob_data,
   output logic                       stu__sys__valid,
   output logic [1:0]                 stu__sys__cntl,
   input  logic                       sys__stu__ready,
   output logic [TYPE_W-1:0]          stu__sys__type,
   output logic [DATA_W-1:0]          stu__sys__data,
   output logic [OOB_W-1:0]           stu__sys__oob_data,
`ifdef STACK_UP_ARB_PROTO_CHK_EN
   output logic [NUM_CHAN-1:0]        stu__sys__proto_err,
`endif
   output logic [CW-1:0]              stu__sys__chan
);

   localparam int FW = 2 + TYPE_W + DATA_W + OOB_W;

   logic [NUM_CHAN-1:0] empty;
   logic [NUM_CHAN-1:0] full;
   logic [NUM_CHAN-1:0] push;
   logic [NUM_CHAN-1:0] pop;
   logic [FW-1:0]       head [NUM_CHAN];

   arb_state_e    state_q;
   logic [CW-1:0] gnt_q;
   logic [CW-1:0] last_q;
   logic [CW-1:0] rr_sel;
   logic          rr_hit;
   logic [CW-1:0] gnt_c;
   logic          out_v;
   logic          fire;
   logic [FW-1:0] out_w;

   for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
      assign stu__mgr__ready[i] = ~full[i];
      assign push[i] = mgr__stu__valid[i] & ~full[i];
      assign pop[i]  = fire && (gnt_c == CW'(i));

      stack_up_arb_fifo #(
         .W     (FW),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk_i   (clk),
         .rst_ni  (reset_poweron),
         .push_i  (push[i]),
         .wdata_i ({mgr__stu__cntl[2*i +: 2],
                    mgr__stu__type[TYPE_W*i +: TYPE_W],
                    mgr__stu__data[DATA_W*i +: DATA_W],
                    mgr__stu__oob_data[OOB_W*i +: OOB_W]}),
         .pop_i   (pop[i]),
         .rdata_o (head[i]),
         .empty_o (empty[i]),
         .full_o  (full[i])
      );

`ifdef STACK_UP_ARB_PROTO_CHK_EN
      logic [1:0] c;
      logic       in_pkt_q;
      logic       err_q;

      assign c = mgr__stu__cntl[2*i +: 2];
      assign stu__sys__proto_err[i] = err_q;

      // SOM bit set while in-packet, or continuation while idle
      always_ff @(posedge clk or negedge reset_poweron) begin
         if (!reset_poweron) begin
            in_pkt_q <= 1'b0;
            err_q    <= 1'b0;
         end else if (push[i]) begin
            in_pkt_q <= (c == CNTL_SOM) || (c == CNTL_MOM);
            if (in_pkt_q ? c[0] : ((c == CNTL_MOM) || (c == CNTL_EOM)))
               err_q <= 1'b1;
         end
      end
`endif
   end

   always_comb begin
      logic [CW:0] s;
      s      = '0;
      rr_sel = last_q;
      rr_hit = 1'b0;
      for (int k = 1; k <= NUM_CHAN; k++) begin
         s = {1'b0, last_q} + (CW+1)'(k);
         if (s >= (CW+1)'(NUM_CHAN)) s = s - (CW+1)'(NUM_CHAN);
         if (!rr_hit && !empty[s[CW-1:0]]) begin
            rr_hit = 1'b1;
            rr_sel = s[CW-1:0];
         end
      end
   end

   always_comb begin
      gnt_c = gnt_q;
      out_v = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            gnt_c = rr_sel;
            out_v = rr_hit;
         end
         ST_XFER: begin
            gnt_c = gnt_q;
            out_v = !empty[gnt_q];
         end
         default: ;
      endcase
   end

   assign out_w = head[gnt_c];
   assign fire  = out_v && sys__stu__ready;

   always_ff @(posedge clk or negedge reset_poweron) begin
      if (!reset_poweron) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         last_q  <= CW'(NUM_CHAN - 1);
      end else if (fire && is_eom(out_w[FW-1 -: 2])) begin
         state_q <= ST_IDLE;
         last_q  <= gnt_c;
      end else if (out_v) begin
         state_q <= ST_XFER;
         gnt_q   <= gnt_c;
      end
   end

   assign stu__sys__valid = out_v;
   assign stu__sys__chan  = gnt_c;
   assign {stu__sys__cntl, stu__sys__type,
           stu__sys__data, stu__sys__oob_data} = out_w;

endmodule

// File: tb/tb_stack_up_arbiter.sv
// Directed-vector bench for stack_up_arbiter, 4 channels.
// Define STACK_UP_ARB_PROTO_CHK_EN to also cover the framing checker.
module tb_stack_up_arbiter;
   import stack_up_arbiter_pkg::*;

   localparam int NC = 4;
   localparam int DW = 16;
   localparam int OW = 8;
   localparam int TW = 2;
   localparam int FD = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NC-1:0]     mv;
   logic [2*NC-1:0]   mc;
   logic [TW*NC-1:0]  mt;
   logic [DW*NC-1:0]  md;
   logic [OW*NC-1:0]  mo;
   logic [NC-1:0]     mr;
   logic              sv;
   logic [1:0]        sc;
   logic              sr;
   logic [TW-1:0]     st;
   logic [DW-1:0]     sd;
   logic [OW-1:0]     so;
   logic [1:0]        sch;
`ifdef STACK_UP_ARB_PROTO_CHK_EN
   logic [NC-1:0]     perr;
`endif

   int n_vec = 0;
   int n_bad = 0;

   logic [1:0] pk3 [3];
   logic [1:0] pk4 [4];

   always #5 clk = ~clk;

   stack_up_arbiter #(
      .NUM_CHAN   (NC),
      .DATA_W     (DW),
      .OOB_W      (OW),
      .TYPE_W     (TW),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk                 (clk),
      .reset_poweron       (rst_n),
      .mgr__stu__valid     (mv),
      .mgr__stu__cntl      (mc),
      .stu__mgr__ready     (mr),
      .mgr__stu__type      (mt),
      .mgr__stu__data      (md),
      .mgr__stu__oob_data  (mo),
      .stu__sys__valid     (sv),
      .stu__sys__cntl      (sc),
      .sys__stu__ready     (sr),
      .stu__sys__type      (st),
      .stu__sys__data      (sd),
      .stu__sys__oob_data  (so),
`ifdef STACK_UP_ARB_PROTO_CHK_EN
      .stu__sys__proto_err (perr),
`endif
      .stu__sys__chan      (sch)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int ch, input logic [1:0] c,
                      input logic [15:0] d);
      mv[ch]           = 1'b1;
      mc[2*ch +: 2]    = c;
      mt[TW*ch +: TW]  = TW'(ch);
      md[DW*ch +: DW]  = d;
      mo[OW*ch +: OW]  = d[7:0] ^ 8'h5A;
   endtask

   task automatic idle();
      mv = '0;
   endtask

   // word expected on the merged output: valid, tag, framing, fields
   task automatic see(input string tag, input int ch,
                      input logic [1:0] c, input logic [15:0] d);
      logic [1:0] cv;
      cv = 2'(ch);
      chk(tag, {33'b0, sv, sch, sc, st, sd, so},
          {33'b0, 1'b1, cv, c, cv, d, d[7:0] ^ 8'h5A});
   endtask

   initial begin
      pk3 = '{CNTL_SOM, CNTL_MOM, CNTL_EOM};
      pk4 = '{CNTL_SOM, CNTL_MOM, CNTL_MOM, CNTL_EOM};
      mv = '0; mc = '0; mt = '0; md = '0; mo = '0;
      sr = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 64'(sv), 64'd0);
      chk("rst_ready", 64'(mr), 64'hF);
`ifdef STACK_UP_ARB_PROTO_CHK_EN
      chk("rst_perr", 64'(perr), 64'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // single SOM_EOM word on ch2
      put(2, CNTL_SOM_EOM, 16'hA5A5);
      chk("t1_pre", 64'(sv), 64'd0);
      step();
      idle();
      see("t1_out", 2, CNTL_SOM_EOM, 16'hA5A5);
      step();
      chk("t1_done", 64'(sv), 64'd0);

      // ch0 and ch1 3-word packets together
      for (int k = 0; k < 3; k++) begin
         put(0, pk3[k], 16'(16'h0100 + k));
         put(1, pk3[k], 16'(16'h0200 + k));
         step();
         see("t2_ch0", 0, pk3[k], 16'(16'h0100 + k));
      end
      idle();
      for (int k = 0; k < 3; k++) begin
         step();
         see("t2_ch1", 1, pk3[k], 16'(16'h0200 + k));
      end
      step();
      chk("t2_done", 64'(sv), 64'd0);

      // ch3 fills its FIFO while downstream stalls
      sr = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("t3_rdy_fill", 64'(mr[3]), 64'd1);
         put(3, pk4[k], 16'(16'h0300 + k));
         step();
      end
      idle();
      chk("t3_full", 64'(mr[3]), 64'd0);
      see("t3_head", 3, CNTL_SOM, 16'h0300);
      step();
      see("t3_stable", 3, CNTL_SOM, 16'h0300);
      chk("t3_full2", 64'(mr[3]), 64'd0);
      sr = 1'b1;
      step();
      see("t3_w1", 3, CNTL_MOM, 16'h0301);
      chk("t3_rdy_back", 64'(mr[3]), 64'd1);
      step();
      see("t3_w2", 3, CNTL_MOM, 16'h0302);
      step();
      see("t3_w3", 3, CNTL_EOM, 16'h0303);
      step();
      chk("t3_done", 64'(sv), 64'd0);

      // ch1 starves mid-packet with ch0 waiting
      put(1, CNTL_SOM, 16'h0110);
      step();
      idle();
      see("t4_som", 1, CNTL_SOM, 16'h0110);
      put(0, CNTL_SOM_EOM, 16'h00AA);
      step();
      idle();
      chk("t4_stall", 64'(sv), 64'd0);
      repeat (4) begin
         step();
         chk("t4_stall", 64'(sv), 64'd0);
      end
      put(1, CNTL_EOM, 16'h0111);
      step();
      idle();
      see("t4_eom", 1, CNTL_EOM, 16'h0111);
      step();
      see("t4_ch0", 0, CNTL_SOM_EOM, 16'h00AA);
      step();
      chk("t4_done", 64'(sv), 64'd0);

      // reset in the middle of a ch0 packet
      sr = 1'b0;
      put(0, CNTL_SOM, 16'h00C0);
      step();
      put(0, CNTL_MOM, 16'h00C1);
      see("t5_som", 0, CNTL_SOM, 16'h00C0);
      step();
      idle();
      see("t5_pre", 0, CNTL_SOM, 16'h00C0);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_valid", 64'(sv), 64'd0);
      chk("t5_rst_ready", 64'(mr), 64'hF);
      @(negedge clk);
      rst_n = 1'b1;
      sr = 1'b1;
      step();
      chk("t5_flushed", 64'(sv), 64'd0);
      put(0, CNTL_SOM_EOM, 16'h00D0);
      put(1, CNTL_SOM_EOM, 16'h01D0);
      step();
      idle();
      see("t5_first", 0, CNTL_SOM_EOM, 16'h00D0);
      step();
      see("t5_second", 1, CNTL_SOM_EOM, 16'h01D0);
      step();
      chk("t5_done", 64'(sv), 64'd0);

`ifdef STACK_UP_ARB_PROTO_CHK_EN
      // MOM on an idle channel is flagged but still forwarded
      chk("t6_pre", 64'(perr), 64'd0);
      put(2, CNTL_MOM, 16'h02EE);
      step();
      idle();
      chk("t6_err", 64'(perr), 64'h4);
      see("t6_fwd", 2, CNTL_MOM, 16'h02EE);
      step();
      put(2, CNTL_EOM, 16'h02EF);
      step();
      idle();
      see("t6_eom", 2, CNTL_EOM, 16'h02EF);
      step();
      chk("t6_held", 64'(perr), 64'h4);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_cleared", 64'(perr), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
